// File: rtl/struct_word_packer.sv
// struct_word_packer
// Packs a stream of 4-bit field beats into one 4*NIBBLES-bit word and holds
// the finished word under a valid/ready handshake. A word closes when its last
// field is written or when in_last arrives early; unfilled fields take PAD.
//
// Ports:
//   clk, rst     clock (rising edge), asynchronous active-high reset
//   in_valid     beat present on in_nib
//   in_ready     packer can take the beat this cycle
//   in_nib       field value
//   in_last      beat closes the current word (qualified by in_valid)
//   out_valid    out_data holds a completed word
//   out_ready    consumer takes the word this cycle
//   out_data     packed word, field 0 in the LSB nibble
//   out_partial  word was closed early by in_last
module struct_word_packer #(
  parameter int unsigned NIBBLES = 8,
  parameter logic [3:0]  PAD     = 4'h0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_nib,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] out_data,
  output logic                 out_partial
);

  localparam int unsigned CntW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int unsigned W    = 4 * NIBBLES;
  localparam logic [CntW-1:0] LastIdx = CntW'(NIBBLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    asm_q, asm_d;
  logic            valid_q, valid_d;
  logic [W-1:0]    data_q, data_d;
  logic            partial_q, partial_d;

  logic            close_cand;
  logic            accept;
  logic [31:0]     cnt_ext;
  logic [W-1:0]    word_closed;

  assign close_cand = (cnt_q == LastIdx) || in_last;
  // Only a closing beat needs the output register, so only it can stall.
  assign in_ready   = !(close_cand && valid_q && !out_ready);
  assign accept     = in_valid && in_ready;
  assign cnt_ext    = 32'(cnt_q);

  // Word as it would look if the current beat closed it.
  always_comb begin
    word_closed = '0;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (i < cnt_ext) begin
        word_closed[4*i +: 4] = asm_q[4*i +: 4];
      end else if (i == cnt_ext) begin
        word_closed[4*i +: 4] = in_nib;
      end else begin
        word_closed[4*i +: 4] = PAD;
      end
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    asm_d     = asm_q;
    valid_d   = valid_q;
    data_d    = data_q;
    partial_d = partial_q;

    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end

    if (accept) begin
      if (close_cand) begin
        cnt_d     = '0;
        asm_d     = '0;
        // A load on the same edge as a take keeps out_valid high: no bubble.
        valid_d   = 1'b1;
        data_d    = word_closed;
        partial_d = (cnt_q != LastIdx);
      end else begin
        cnt_d                 = cnt_q + CntW'(1);
        asm_d[4*cnt_q +: 4]   = in_nib;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      asm_q     <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      partial_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      asm_q     <= asm_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      partial_q <= partial_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_data    = data_q;
  assign out_partial = partial_q;

endmodule

// File: tb/tb_struct_word_packer.sv
module tb_struct_word_packer;

  localparam int unsigned N   = 8;
  localparam logic [3:0]  PAD = 4'h0;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_nib;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic          out_partial;

  int total = 0;
  int bad   = 0;

  // Reference model: fields of the word being built, plus the held output.
  logic [3:0]  m_q[$];
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_partial;
  logic        m_ready;
  logic        obs_ready;

  struct_word_packer #(.NIBBLES(N), .PAD(PAD)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_nib     (in_nib),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_partial(out_partial)
  );

  always #5 clk = ~clk;

  task automatic m_reset();
    m_q.delete();
    m_valid   = 1'b0;
    m_data    = '0;
    m_partial = 1'b0;
  endtask

  // Drive one cycle from a negedge, sample in_ready, advance, update the model.
  task automatic step(input logic v, input logic [3:0] n, input logic l, input logic r);
    logic [31:0] w;
    logic        take;
    in_valid = v; in_nib = n; in_last = l; out_ready = r;
    #1;
    obs_ready = in_ready;
    m_ready   = !(((m_q.size() == N - 1) || l) && m_valid && !r);
    @(posedge clk);
    take = m_valid && r;
    if (v && m_ready) begin
      m_q.push_back(n);
      if (m_q.size() == N || l) begin
        w = '0;
        for (int i = 0; i < N; i++) begin
          w = w | ({28'h0, (i < m_q.size()) ? m_q[i] : PAD} << (4 * i));
        end
        m_partial = (m_q.size() != N);
        m_data    = w;
        m_valid   = 1'b1;
        take      = 1'b0;
        m_q.delete();
      end
    end
    if (take) m_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input logic r);
    for (int i = 0; i < N; i++) step(1'b1, w[4*i +: 4], 1'b0, r);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 0; in_nib = 0; in_last = 0; out_ready = 0;
    m_reset();
    repeat (2) @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_partial !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b d=%h p=%b want 0/0/0", out_valid, out_data,
               out_partial);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_word();
    send_word(32'ha7107338, 1'b1);
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'ha7107338 || out_partial !== 1'b0) begin
      bad++;
      $display("FAIL full_word: got v=%b d=%h p=%b want 1/a7107338/0", out_valid, out_data,
               out_partial);
    end
    step(1'b0, 4'h0, 1'b0, 1'b1);
    total++;
    if (out_valid !== m_valid) begin
      bad++;
      $display("FAIL full_word_drain: got v=%b want %b", out_valid, m_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] nxt;
    nxt = 32'h80ad046a;
    send_word(32'h8f8259e4, 1'b0);
    for (int i = 0; i < N - 1; i++) begin
      step(1'b1, nxt[4*i +: 4], 1'b0, 1'b0);
      total++;
      if (obs_ready !== 1'b1) begin
        bad++;
        $display("FAIL bp_accept_%0d: got in_ready=%b want 1", i, obs_ready);
      end
    end
    step(1'b1, nxt[31:28], 1'b0, 1'b0);
    total++;
    if (obs_ready !== 1'b0 || out_data !== 32'h8f8259e4 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL bp_stall: got rdy=%b d=%h v=%b want 0/8f8259e4/1", obs_ready, out_data,
               out_valid);
    end
    step(1'b1, nxt[31:28], 1'b0, 1'b1);
    total++;
    if (obs_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== 32'h80ad046a ||
        out_data !== m_data) begin
      bad++;
      $display("FAIL bp_release: got rdy=%b v=%b d=%h want 1/1/80ad046a", obs_ready,
               out_valid, out_data);
    end
    step(1'b0, 4'h0, 1'b0, 1'b1);
  endtask

  task automatic test_early_close();
    step(1'b1, 4'he, 1'b0, 1'b1);
    step(1'b1, 4'h4, 1'b0, 1'b1);
    step(1'b1, 4'h9, 1'b1, 1'b1);
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'h0000094e || out_partial !== 1'b1) begin
      bad++;
      $display("FAIL early_close: got v=%b d=%h p=%b want 1/0000094e/1", out_valid, out_data,
               out_partial);
    end
    step(1'b1, 4'h5, 1'b1, 1'b1);
    total++;
    if (out_data !== 32'h00000005 || out_partial !== 1'b1 || out_data !== m_data) begin
      bad++;
      $display("FAIL first_beat_last: got d=%h p=%b want 00000005/1", out_data, out_partial);
    end
    step(1'b0, 4'h0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [63:0] ws;
    int first_at, second_at;
    ws = {32'he6458a2d, 32'hbf93017e};
    first_at = -1; second_at = -1;
    for (int i = 0; i < 2 * N; i++) begin
      step(1'b1, ws[4*i +: 4], 1'b0, 1'b1);
      total++;
      if (obs_ready !== 1'b1 || out_valid !== m_valid || out_data !== m_data) begin
        bad++;
        $display("FAIL b2b_%0d: got rdy=%b v=%b d=%h want 1/%b/%h", i, obs_ready, out_valid,
                 out_data, m_valid, m_data);
      end
      if (out_valid && out_data == 32'hbf93017e && first_at < 0) first_at = i;
      if (out_valid && out_data == 32'he6458a2d && second_at < 0) second_at = i;
    end
    total++;
    if (second_at - first_at !== 8 || first_at < 0) begin
      bad++;
      $display("FAIL b2b_spacing: got first=%0d second=%0d want gap 8", first_at, second_at);
    end
    step(1'b0, 4'h0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_word();
    send_word(32'h12345678, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_partial !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got v=%b d=%h p=%b want 0/0/0", out_valid, out_data,
               out_partial);
    end
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    send_word(32'ha7107338, 1'b0);
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'ha7107338 || out_partial !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_word: got v=%b d=%h p=%b want 1/a7107338/0", out_valid,
               out_data, out_partial);
    end
    step(1'b0, 4'h0, 1'b0, 1'b1);
  endtask

  task automatic test_idle();
    logic [31:0] w;
    w = 32'h3c5a9e17;
    for (int i = 0; i < 3; i++) step(1'b1, w[4*i +: 4], 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b1);
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL idle_%0d: got out_valid=%b want 0", i, out_valid);
      end
    end
    for (int i = 3; i < N; i++) step(1'b1, w[4*i +: 4], 1'b0, 1'b1);
    total++;
    if (out_valid !== 1'b1 || out_data !== w) begin
      bad++;
      $display("FAIL idle_resume: got v=%b d=%h want 1/%h", out_valid, out_data, w);
    end
    step(1'b0, 4'h0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 2) != 0));
      total++;
      if (obs_ready !== m_ready || out_valid !== m_valid || out_data !== m_data ||
          out_partial !== m_partial) begin
        bad++;
        $display("FAIL random_%0d: got rdy=%b v=%b d=%h p=%b want %b/%b/%h/%b", i, obs_ready,
                 out_valid, out_data, out_partial, m_ready, m_valid, m_data, m_partial);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_backpressure();
    test_early_close();
    test_back_to_back();
    test_reset_mid_word();
    test_idle();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/struct_word_packer.md
Name: struct_word_packer

Overview:
- Upstream feeder for the packed-struct field-select stage (32-bit word in, p1/p2 select, out_x/out_y nibbles).
- Assembles a stream of 4-bit field beats into one packed 32-bit word.
- Holds the finished word in an output register under a valid/ready handshake until the consumer takes it.
- Supports early close of a word; unfilled fields are padded with a constant.

Parameters:
- NIBBLES, 8, number of 4-bit fields per word; out_data width = 4*NIBBLES.
- PAD, 4'h0, value written into the unfilled fields when a word is closed early.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  beat present on in_nib.
- in_ready  output  1  packer can accept the beat this cycle.
- in_nib  input  4  field value.
- in_last  input  1  beat closes the current word; qualified by in_valid.
- out_valid  output  1  out_data holds a completed word.
- out_ready  input  1  consumer takes the word this cycle.
- out_data  output  4*NIBBLES  packed word.
- out_partial  output  1  word was closed by in_last before all NIBBLES fields were filled.

Behaviour:
- One clock: clk. Reset: rst, asynchronous, active-high.
- Reset values: out_valid=0, out_data=0, out_partial=0, internal fill count=0, assembly register=0. A reset mid-word discards the partial word; the next accepted beat becomes field 0.
- Accept rule: a beat is accepted when in_valid && in_ready.
- Field placement: beat k of a word is written to bits [4k+3:4k]. Field 0 is the LSB nibble.
- Closing beat: a beat closes the word when fill count == NIBBLES-1 or in_last=1.
- Non-closing beat: writes its field and increments the fill count.
- On a closing beat:
  - Fields above k are filled with PAD.
  - The word moves to out_data on the same edge, so out_valid rises the next cycle (1-cycle latency).
  - out_partial = (k != NIBBLES-1).
  - Fill count returns to 0 (wrap).
- in_ready = !(closing-beat candidate && out_valid && !out_ready).
  - in_ready is combinational on fill count, in_last, out_valid and out_ready.
  - Non-closing beats are always accepted, even while a word is held.
- Output handshake:
  - out_valid and out_data stay stable while out_valid && !out_ready.
  - out_valid clears on out_valid && out_ready, unless a closing beat is accepted on the same edge.
  - In that case the new word loads and out_valid stays 1, giving back-to-back words with no bubble.
- in_last on the NIBBLES-1 beat: full word, out_partial=0.
- in_last on the first beat of a word (k=0): legal. Result is field 0 = in_nib, all other fields = PAD.
- in_last while in_valid=0: ignored.
- in_nib/in_last with in_valid=0: no effect on any state.
- Counter width: clog2(NIBBLES), minimum 1 bit. The count never exceeds NIBBLES-1.

Test Plan:
- Full word, no backpressure:
  - Stimulus: out_ready=1, beats 8,3,3,7,0,1,7,a.
  - Required: the cycle after beat 8 (the last beat, a), out_valid=1, out_data=32'ha7107338, out_partial=0.
- Backpressure:
  - Stimulus: out_ready=0; word 32'h8f8259e4 (beats 4,e,9,5,2,8,f,8), then 7 beats of the next word, then an 8th beat with in_valid=1.
  - Required: the 7 beats are accepted; in_ready=0 on the 8th; out_data holds 32'h8f8259e4.
  - Stimulus: raise out_ready.
  - Required: in_ready=1 that cycle; the next word 32'h80ad046a appears the cycle after.
- Early close:
  - Stimulus: beats e,4,9 with in_last on beat 9, PAD=0.
  - Required: out_data=32'h0000094e, out_partial=1, and the next beat lands in bits [3:0].
- Back-to-back:
  - Stimulus: out_ready held 1; 16 consecutive beats forming 32'hbf93017e then 32'he6458a2d.
  - Required: in_ready stays 1 throughout; out_valid stays 1 across the boundary; the second word appears 8 cycles after the first.
- Reset mid-word:
  - Stimulus: 5 beats, assert rst asynchronously between edges, release, then 8 beats of 32'ha7107338.
  - Required: outputs drop to 0 immediately on rst; the result is exactly 32'ha7107338 with no residue.
- Idle/garbage:
  - Stimulus: in_valid=0 while in_nib and in_last toggle for 10 cycles.
  - Required: out_valid stays 0 and the fill count is unchanged.
